// File: rtl/soft_rst_seq.sv
// rtl/soft_rst_seq.sv - shares one soft-reset engine between several reset sources
module soft_rst_seq #(
    parameter int unsigned       NREQ  = 4,
    parameter int unsigned       TMO_W = 16,
    parameter logic [TMO_W-1:0]  TMO   = TMO_W'(50000),
    parameter logic [7:0]        COOL  = 8'd16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] ack_o,
    output logic [NREQ-1:0] err_o,
    output logic            req_soft_rst,
    input  logic            soft_rst_dne,
    output logic            busy,
    output logic [NREQ-1:0] cause,
    output logic            tmo_err,
    input  logic            clr_err
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        DRAIN,
        COOLDN
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO - 1'b1;
    localparam logic [7:0]       COOL_LAST = COOL - 8'd1;

    state_t            state, state_n;
    logic [NREQ-1:0]   mask, mask_n;
    logic [NREQ-1:0]   cause_n, ack_n, err_n;
    logic [TMO_W-1:0]  tcnt, tcnt_n;
    logic [7:0]        ccnt, ccnt_n;
    logic              req_n, tmo_n;

    always_comb begin
        state_n = state;
        mask_n  = mask;
        cause_n = cause;
        tcnt_n  = tcnt;
        ccnt_n  = ccnt;
        req_n   = req_soft_rst;
        ack_n   = '0;
        err_n   = '0;
        // a timeout in this cycle overrides a concurrent clear below
        tmo_n   = tmo_err & ~clr_err;

        case (state)
            IDLE: begin
                if (req_i != '0) begin
                    mask_n  = req_i;
                    cause_n = req_i;
                    tcnt_n  = '0;
                    req_n   = 1'b1;
                    state_n = ASSERT;
                end
            end
            ASSERT: begin
                if (soft_rst_dne) begin
                    ack_n   = mask;
                    req_n   = 1'b0;
                    state_n = DRAIN;
                end else if (tcnt == TMO_LAST) begin
                    err_n   = mask;
                    tmo_n   = 1'b1;
                    req_n   = 1'b0;
                    state_n = DRAIN;
                end else if (tcnt != '1) begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!soft_rst_dne) begin
                    ccnt_n  = '0;
                    state_n = COOLDN;
                end
            end
            COOLDN: begin
                if (ccnt == COOL_LAST) begin
                    state_n = IDLE;
                end else begin
                    ccnt_n = ccnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mask         <= '0;
            cause        <= '0;
            tcnt         <= '0;
            ccnt         <= '0;
            req_soft_rst <= 1'b0;
            ack_o        <= '0;
            err_o        <= '0;
            tmo_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            mask         <= mask_n;
            cause        <= cause_n;
            tcnt         <= tcnt_n;
            ccnt         <= ccnt_n;
            req_soft_rst <= req_n;
            ack_o        <= ack_n;
            err_o        <= err_n;
            tmo_err      <= tmo_n;
            busy         <= (state_n != IDLE);
        end
    end

endmodule
